// File: rtl/seq_sll_unit.sv
// Multi-cycle 32-bit logical left shifter: one barrel stage (16, 8, 4, 2, 1) per clock,
// with a start/result_valid handshake and a flag for any 1 bit shifted out past bit 31.
module seq_sll_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             lost_nz
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       stage;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   amt;
    logic             lost;
    logic [WIDTH-1:0] stage_val;
    logic             stage_out;
    logic             accept;

    assign accept = start && (state == IDLE || state == DONE);

    // One shared stage: stage k shifts by 2^(4-k) when amt bit (4-k) is set.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        stage_val = work;
        stage_out = 1'b0;
        case (stage)
            3'd0: if (amt[4]) begin
                stage_val = {work[15:0], 16'b0};
                stage_out = |work[31:16];
            end
            3'd1: if (amt[3]) begin
                stage_val = {work[23:0], 8'b0};
                stage_out = |work[31:24];
            end
            3'd2: if (amt[2]) begin
                stage_val = {work[27:0], 4'b0};
                stage_out = |work[31:28];
            end
            3'd3: if (amt[1]) begin
                stage_val = {work[29:0], 2'b0};
                stage_out = |work[31:30];
            end
            3'd4: if (amt[0]) begin
                stage_val = {work[30:0], 1'b0};
                stage_out = work[31];
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (stage == 3'd4) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stage   <= 3'd0;
            work    <= '0;
            amt     <= '0;
            lost    <= 1'b0;
            result  <= '0;
            lost_nz <= 1'b0;
        end else if (accept) begin
            stage <= 3'd0;
            work  <= data_in;
            amt   <= shamt;
            lost  <= 1'b0;
        end else if (state == SHIFT) begin
            work  <= stage_val;
            lost  <= lost | stage_out;
            stage <= stage + 3'd1;
            // Result registers change only here, so they hold through DONE and the next SHIFT.
            if (stage == 3'd4) begin
                result  <= stage_val;
                lost_nz <= lost | stage_out;
            end
        end
    end

    always_comb begin
        busy         = (state == SHIFT);
        result_valid = (state == DONE);
    end

endmodule
